// File: rtl/full_adder_reg_if.sv
// Operand/result bundle for full_adder_reg: the producer drives operands with
// a valid qualifier, the adder returns a registered result with its own valid.
interface full_adder_reg_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // Producer side: supplies operands, observes results.
  modport master (
    output in_valid, a, b, c,
    input  out_valid, sum, carry
  );

  // Adder side: consumes operands, returns results.
  modport slave (
    input  in_valid, a, b, c,
    output out_valid, sum, carry
  );
endinterface

// File: rtl/full_adder_reg_fa_cell.sv
// Purely combinational 1-bit full adder; one link of the ripple chain.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (b & cin) | (a & cin);
endmodule

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {carry, sum} = a + b + c, one cycle latency,
// every output straight from a flop.
module full_adder_reg #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  full_adder_reg_if.slave    bus
);
  // Ripple chain: chain[0] is the carry-in, chain[WIDTH] the MSB carry-out.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_comb;

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  assign chain[0] = bus.c;

  // One full-adder cell per bit, carry rippling LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (chain[i]),
      .s    (sum_comb[i]),
      .cout (chain[i+1])
    );
  end

  // Capture the result on valid cycles; hold data and drop valid otherwise.
  // NOTE: non-blocking (<=) for all flop updates so every register samples
  // pre-edge values; reset is asynchronous, so rst sits in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      sum_q   <= sum_comb;
      carry_q <= chain[WIDTH];
      valid_q <= 1'b1;
    end else begin
      // NOTE: data flops load only under in_valid, so don't-care operands on
      // idle cycles never reach the registers.
      valid_q <= 1'b0;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and randomized checks of full_adder_reg at WIDTH 1, 8 and 16.
module tb_full_adder_reg;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  full_adder_reg_if #(.WIDTH(1))  if1  ();
  full_adder_reg_if #(.WIDTH(8))  if8  ();
  full_adder_reg_if #(.WIDTH(16)) if16 ();

  full_adder_reg #(.WIDTH(1))  u_w1  (.clk(clk), .rst(rst), .bus(if1));
  full_adder_reg #(.WIDTH(8))  u_w8  (.clk(clk), .rst(rst), .bus(if8));
  full_adder_reg #(.WIDTH(16)) u_w16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    logic v; logic a; logic b; logic c;
    logic ev; logic es; logic ec;
  } vec1_t;

  typedef struct {
    logic v; logic [7:0] a; logic [7:0] b; logic c;
    logic ev; logic [7:0] es; logic ec;
  } vec8_t;

  vec1_t t1 [20];
  vec8_t t8 [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        rv, rc;
    logic [15:0] ra, rb;
    logic        exp_v;
    logic [15:0] exp_s;
    logic        exp_c;
    logic [16:0] full;

    // WIDTH=1: reset result, consecutive valids, then all 8 inputs with gaps.
    t1[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    t1[5]  = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b0};
    t1[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[7]  = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b1};
    t1[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[9]  = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0};
    t1[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[11] = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b1};
    t1[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[13] = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b0};
    t1[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t1[15] = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b1};
    t1[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[17] = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b0};
    t1[18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[19] = '{1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b1, 1'b1};

    // WIDTH=8: wrap-around, a carry rippling into the MSB, then an idle hold.
    t8[0] = '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    t8[1] = '{1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0};
    t8[2] = '{1'b0, 8'hxx, 8'hxx, 1'bx, 1'b0, 8'h80, 1'b0};

    if1.in_valid  = 1'b0; if1.a  = '0; if1.b  = '0; if1.c  = 1'b0;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.c  = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.c = 1'b0;

    rst = 1'b1;
    #2;
    check("rst_w1_valid", 64'(if1.out_valid), 64'd0);
    check("rst_w1_sum",   64'(if1.sum),       64'd0);
    check("rst_w1_carry", 64'(if1.carry),     64'd0);
    check("rst_w8_sum",   64'(if8.sum),       64'd0);
    #10;
    rst = 1'b0;  // released at t=12, first capture at the t=15 edge

    for (int i = 0; i < 20; i++) begin
      if1.in_valid = t1[i].v; if1.a = t1[i].a; if1.b = t1[i].b; if1.c = t1[i].c;
      next_edge();
      check($sformatf("w1_valid[%0d]", i), 64'(if1.out_valid), 64'(t1[i].ev));
      check($sformatf("w1_sum[%0d]", i),   64'(if1.sum),       64'(t1[i].es));
      check($sformatf("w1_carry[%0d]", i), 64'(if1.carry),     64'(t1[i].ec));
    end
    if1.in_valid = 1'b0;

    for (int i = 0; i < 3; i++) begin
      if8.in_valid = t8[i].v; if8.a = t8[i].a; if8.b = t8[i].b; if8.c = t8[i].c;
      next_edge();
      check($sformatf("w8_valid[%0d]", i), 64'(if8.out_valid), 64'(t8[i].ev));
      check($sformatf("w8_sum[%0d]", i),   64'(if8.sum),       64'(t8[i].es));
      check($sformatf("w8_carry[%0d]", i), 64'(if8.carry),     64'(t8[i].ec));
    end

    // Reset pulsed mid-cycle while a valid input is pending: it is discarded.
    if8.in_valid = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.c = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("w8_async_rst_sum",   64'(if8.sum),       64'd0);
    check("w8_async_rst_carry", 64'(if8.carry),     64'd0);
    check("w8_async_rst_valid", 64'(if8.out_valid), 64'd0);
    next_edge();
    check("w8_rst_held_sum",   64'(if8.sum),       64'd0);
    check("w8_rst_held_valid", 64'(if8.out_valid), 64'd0);
    #2;
    rst = 1'b0;
    if8.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_edge();
      check($sformatf("w8_post_rst_sum[%0d]", i),   64'(if8.sum),       64'd0);
      check($sformatf("w8_post_rst_carry[%0d]", i), 64'(if8.carry),     64'd0);
      check($sformatf("w8_post_rst_valid[%0d]", i), 64'(if8.out_valid), 64'd0);
    end

    // WIDTH=16: random traffic against an a+b+c reference delayed one cycle.
    exp_v = 1'b0; exp_s = '0; exp_c = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
      if (i == 0) begin rv = 1'b1; ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; end
      if (i == 1) begin rv = 1'b1; ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      if1.in_valid = 1'b0;
      if16.in_valid = rv; if16.a = ra; if16.b = rb; if16.c = rc;
      if (rv) begin
        full  = 17'(ra) + 17'(rb) + 17'(rc);
        exp_s = full[15:0];
        exp_c = full[16];
      end
      exp_v = rv;
      next_edge();
      check($sformatf("w16_rand[%0d]", i),
            64'({if16.out_valid, if16.carry, if16.sum}),
            64'({exp_v, exp_c, exp_s}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
- Registered ripple-carry full adder: sum = a XOR b XOR c, carry = majority(a, b, c), extended bitwise over WIDTH bits.
- Leaf arithmetic primitive for datapath blocks that need an add with carry-in and carry-out at a clean register boundary.
- WIDTH = 1 is the classic single-bit full adder.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b, c this cycle.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c  input  1  carry-in.
- out_valid  output  1  sum/carry hold a new result.
- sum  output  WIDTH  registered sum bits.
- carry  output  1  registered carry-out of the MSB.

Behaviour:
- Reset:
  - rst high forces sum = 0, carry = 0 and out_valid = 0 immediately, without waiting for a clock edge.
  - Outputs stay at these values while rst is held.
  - The first capture happens on the first rising clk edge after rst deasserts.
- Arithmetic:
  - Per bit i: s[i] = a[i] ^ b[i] ^ cin[i]; cout[i] = (a[i] & b[i]) | (b[i] & cin[i]) | (a[i] & cin[i]).
  - cin[0] = c and cin[i+1] = cout[i]; carry = cout[WIDTH-1].
  - Equivalent to {carry, sum} = a + b + c computed at WIDTH+1 bits.
- Timing:
  - Latency is exactly 1 cycle.
  - On a rising clk edge with in_valid = 1, sum and carry capture the combinational result and out_valid is set to 1.
  - On a rising clk edge with in_valid = 0, sum and carry hold their previous values and out_valid is cleared to 0.
  - Back-to-back valid inputs give one result per cycle. There is no backpressure and no ready signal.
- Wrap-around: when the result exceeds 2^WIDTH - 1, sum holds the low WIDTH bits and carry = 1. Example: all-ones + 0 + 1 gives sum 0, carry 1.
- Reset mid-operation: asserting rst in the same cycle as in_valid discards that input. No result appears after reset releases.
- X handling: inputs are don't-care while in_valid = 0 and must not propagate into the registers.
- All outputs are driven directly from flops; there is no combinational path from input to output.

Decomposition:
- No shared package is required. WIDTH is the only configuration and stays a module parameter.
- One sub-module, fa_cell: a purely combinational 1-bit full adder with inputs a, b, cin and outputs s, cout.
  - full_adder_reg instantiates WIDTH copies in a generate loop, chaining cout into the next cin.
  - The output register stage sits in full_adder_reg.

Test Plan:
- WIDTH=1, reset then a=0,b=0,c=0 valid -> next cycle sum=0, carry=0, out_valid=1.
- WIDTH=1, sequence (0,1,0), (1,1,1), (1,0,0) on consecutive cycles -> (sum,carry) = (1,0), (1,1), (1,0), each one cycle later; out_valid=1 throughout.
- WIDTH=1, exhaustive 8 input combinations with in_valid gaps between them -> each matches the truth table; out_valid pulses for one cycle per input and outputs hold during gaps.
- WIDTH=8, a=0xFF, b=0x00, c=1 -> sum=0x00, carry=1; then a=0x7F, b=0x01, c=0 -> sum=0x80, carry=0.
- WIDTH=8, a=0xAA, b=0x55, c=1 valid and rst pulsed asynchronously between clk edges in the same cycle -> sum=0, carry=0, out_valid=0 immediately; after release with no valid input, outputs stay 0.
- Random WIDTH=16, 1000 vectors with random in_valid -> {carry,sum} equals the a+b+c reference model delayed 1 cycle; outputs hold when in_valid=0.
